// File: rtl/gcd_sub_engine.sv
// Euclid-by-subtraction GCD controller driving an external combinational subtractor.
// Optional iteration counter output enabled by defining GCD_ITER_COUNT_EN.
module gcd_sub_engine #(
  parameter int WIDTH = 8
`ifdef GCD_ITER_COUNT_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  input  logic [WIDTH-1:0] sub_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic             busy
`ifdef GCD_ITER_COUNT_EN
  , output logic [CNT_WIDTH-1:0] iter_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic             calcEnd;

  assign calcEnd  = (ra == '0) || (rb == '0) || (ra == rb);
  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  // The larger working operand is always the minuend, so the difference never wraps.
  always_comb begin
    sub_a = rb;
    sub_b = ra;
    if (ra >= rb) begin
      sub_a = ra;
      sub_b = rb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ra        <= '0;
      rb        <= '0;
      gcd_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra    <= a_in;
            rb    <= b_in;
            state <= CALC;
          end
        end
        CALC: begin
          if (calcEnd) begin
            gcd_out   <= (ra == '0) ? rb : ra;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (ra > rb) begin
            ra <= sub_res;
          end else begin
            rb <= sub_res;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GCD_ITER_COUNT_EN
  // Counts subtraction steps of the current pair; sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_cnt <= '0;
    end else if (state == IDLE && in_valid) begin
      iter_cnt <= '0;
    end else if (state == CALC && !calcEnd && iter_cnt != '1) begin
      iter_cnt <= iter_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gcd_sub_engine.sv
// Self-checking bench for gcd_sub_engine: directed corner cases plus random pairs
// checked against an arithmetic Euclid reference model.
module tb_gcd_sub_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [7:0] sub_a;
  logic [7:0] sub_b;
  logic [7:0] sub_res;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] gcd_out;
  logic       busy;
`ifdef GCD_ITER_COUNT_EN
  logic [15:0] iter_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int idx;
  int accepted;
  int results[$];
  logic acc;
  logic res;
  logic [7:0] resVal;
  int pa[2] = '{18, 35};
  int pb[2] = '{24, 14};

  always #5 clk = ~clk;

  assign sub_res = sub_a - sub_b;

  gcd_sub_engine #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .sub_a    (sub_a),
    .sub_b    (sub_b),
    .sub_res  (sub_res),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .gcd_out  (gcd_out),
    .busy     (busy)
`ifdef GCD_ITER_COUNT_EN
    , .iter_cnt(iter_cnt)
`endif
  );

  function automatic int refGcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Subtraction steps equal the sum of Euclid quotients, less the final equal-operand step.
  function automatic int refSteps(input int x, input int y);
    int n = 0;
    int t;
    if (x == 0 || y == 0) return 0;
    while (y != 0) begin
      n += x / y;
      t = x % y;
      x = y;
      y = t;
    end
    return n - 1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int a, input int b);
    int n = 0;
    while (!in_ready && n < 500) begin
      tick();
      n++;
    end
    checkOutput("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a_in     = 8'(a);
    b_in     = 8'(b);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic runPair(input int a, input int b);
    int lat = 0;
    int steps;
    steps = refSteps(a, b);
    applyStimulus(a, b);
    while (!out_valid && lat < 600) begin
      tick();
      lat++;
    end
    checkOutput($sformatf("latency(%0d,%0d)", a, b), lat, steps + 1);
    checkOutput($sformatf("gcd(%0d,%0d)", a, b), {24'd0, gcd_out}, refGcd(a, b));
`ifdef GCD_ITER_COUNT_EN
    checkOutput($sformatf("iter_cnt(%0d,%0d)", a, b), {16'd0, iter_cnt}, steps);
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("out_valid_after_handshake", {31'd0, out_valid}, 32'd0);
    checkOutput("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    tick();
    tick();
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_gcd_out", {24'd0, gcd_out}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // (12,8): subtractor pairs, latency and result observed edge by edge
    applyStimulus(12, 8);
    checkOutput("t1_sub_a0", {24'd0, sub_a}, 32'd12);
    checkOutput("t1_sub_b0", {24'd0, sub_b}, 32'd8);
    checkOutput("t1_busy", {31'd0, busy}, 32'd1);
    checkOutput("t1_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    checkOutput("t1_sub_a1", {24'd0, sub_a}, 32'd8);
    checkOutput("t1_sub_b1", {24'd0, sub_b}, 32'd4);
    tick();
    checkOutput("t1_out_valid_early", {31'd0, out_valid}, 32'd0);
    tick();
    checkOutput("t1_out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t1_gcd", {24'd0, gcd_out}, 32'd4);
`ifdef GCD_ITER_COUNT_EN
    checkOutput("t1_iter_cnt", {16'd0, iter_cnt}, 32'd2);
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("t1_out_valid_drop", {31'd0, out_valid}, 32'd0);

    runPair(0, 9);
    runPair(0, 0);
    runPair(9, 0);
    runPair(255, 1);
    runPair(200, 200);

    // Backpressure in DONE with a stray in_valid that must be ignored
    applyStimulus(36, 24);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    in_valid = 1'b1;
    a_in     = 8'd5;
    b_in     = 8'd10;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t4_out_valid_held", {31'd0, out_valid}, 32'd1);
      checkOutput("t4_gcd_held", {24'd0, gcd_out}, 32'd12);
      checkOutput("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
`ifdef GCD_ITER_COUNT_EN
      checkOutput("t4_iter_held", {16'd0, iter_cnt}, 32'd2);
`endif
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    checkOutput("t4_no_stray_accept", {31'd0, busy}, 32'd0);

    // Reset pulse mid-calculation abandons the pair
    applyStimulus(255, 1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("t5_in_ready_in_rst", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("t5_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("t5_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("t5_gcd_out", {24'd0, gcd_out}, 32'd0);
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);
    runPair(18, 24);

    // Back-to-back pairs with both handshakes held asserted
    idx       = 0;
    accepted  = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_in      = 8'(pa[0]);
    b_in      = 8'(pb[0]);
    for (int cyc = 0; cyc < 300 && results.size() < 2; cyc++) begin
      acc    = in_valid && in_ready;
      res    = out_valid && out_ready;
      resVal = gcd_out;
      tick();
      if (acc) begin
        accepted++;
        idx++;
        if (idx < 2) begin
          a_in = 8'(pa[idx]);
          b_in = 8'(pb[idx]);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (res) results.push_back(int'(resVal));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("t6_result_count", results.size(), 32'd2);
    checkOutput("t6_accept_count", accepted, 32'd2);
    if (results.size() >= 1) checkOutput("t6_first", results[0], refGcd(pa[0], pb[0]));
    if (results.size() >= 2) checkOutput("t6_second", results[1], refGcd(pa[1], pb[1]));
    tick();

    for (int i = 0; i < 10; i++) begin
      runPair(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
